spi_connect: RTL and testbench
==============================

// Module: spi_connect
// PURPOSE
//  Draws a Petersen graph (outer pentagon, 5 spokes, inner pentagram) on an ILI9341-style SPI display.
//  On i_start it waits DELAY cycles, rasterises 15 edges (Bresenham) and streams each pixel as
//  CASET/PASET/RAMWR command+data bytes. Sits between top-level start logic and display pins;
//  SCLK is generated externally as ~i_clk, so one MOSI bit is sent per i_clk cycle.
// PARAMETERS
//  DELAY     20       i_clk cycles between accepted i_start and first byte
//  X1..X5    12,23,19,6,2     outer vertex x (16-bit unsigned pixel coords)
//  Y1..Y5    5,12,25,25,12    outer vertex y
//  X1_2..X5_2 12,18,16,8,6    inner vertex x
//  Y1_2..Y5_2 9,13,20,20,13   inner vertex y
//  COLOR     16'hFFFF  RGB565 pixel colour
// PORTS
//  i_clk    in   1  system clock; all logic on rising edge
//  i_rst    in   1  reset, asynchronous, active-high
//  i_start  in   1  1-cycle start pulse; ignored while busy
//  o_mosi   out  1  serial data, MSB first
//  o_dc     out  1  0 = command byte, 1 = data byte
//  o_cs     out  1  chip select, active-low
//  o_done   out  1  high once drawing complete
// BEHAVIOUR
//  - Reset (any time, aborts operation): o_mosi=0, o_dc=0, o_cs=1, o_done=0, FSM->IDLE.
//  - FSM: IDLE -> WAIT(DELAY cycles) -> EDGE_SETUP -> PIXEL (send 13 bytes) -> STEP -> ... -> DONE.
//  - i_start in IDLE or DONE starts a run; o_done clears on that accept. i_start elsewhere ignored.
//  - Edge order (from->to): 1-2,2-3,3-4,4-5,5-1; spokes 1-1_2,2-2_2,3-3_2,4-4_2,5-5_2;
//    pentagram 1_2-3_2,3_2-5_2,5_2-2_2,2_2-4_2,4_2-1_2.
//  - Bresenham, integer, signed 17-bit error; both endpoints drawn; max(|dx|,|dy|)+1 pixels per edge;
//    shared vertices redrawn (no dedup). Must handle all octants, dx=0 and dy=0.
//  - Per pixel (x,y): 2A(c), x[15:8],x[7:0],x[15:8],x[7:0](d), 2B(c), y hi,lo,y hi,lo(d),
//    2C(c), COLOR[15:8],COLOR[7:0](d). 13 bytes, 104 bits.
//  - Byte timing: o_mosi/o_dc change on i_clk rising edge, stable for 8 cycles per byte;
//    at most 2 idle cycles between bytes (o_mosi held, o_dc held).
//  - o_cs falls with first bit of first byte, stays low until last bit of last byte ends, then rises.
//  - DONE: o_cs=1, o_done=1 (level) until reset or next accepted i_start.
// STRUCTURE
//  - Package spi_connect_pkg: CMD_CASET=8'h2A, CMD_PASET=8'h2B, CMD_RAMWR=8'h2C, state enum,
//    edge-index constants (15 edges).
//  - One sub-module: spi_byte_tx (load byte+dc, shift MSB first over 8 cycles, busy/done strobe).
//  - Top: edge table mux from parameters, Bresenham datapath, pixel byte sequencer, FSM.
// TESTING
//  - Reset: assert i_rst mid-clock -> outputs 0,0,1,0 immediately; pulse mid-draw -> same, no further bytes.
//  - Start: i_start pulse -> o_cs low after DELAY(20) +<=2 cycles; first 13 bytes decode to
//    2A 00 0C 00 0C 2B 00 05 00 05 2C FF FF, dc = 0,1111,0,1111,0,11.
//  - Edge 1 (12,5)->(23,12): exactly 12 pixels, last pixel (23,12); edge 6 (12,5)->(12,9): 5 pixels, x const 12.
//  - Totals with defaults: 152 pixels (1976 bytes); o_done high within 50000 cycles; o_cs high after.
//  - i_start during drawing ignored; i_start after done restarts identical byte stream, o_done cleared.
//  - Octant check: edge 3-4 (19,25)->(6,25) negative dx, dy=0 -> 14 pixels x 19 down to 6, y 25.

Source files
------------

// File: rtl/spi_connect_pkg.sv
// Shared constants for the Petersen-graph SPI drawer: display commands, FSM states
// and the fixed edge table (vertex indices 0..4 = outer 1..5, 5..9 = inner 1_2..5_2).
package spi_connect_pkg;

  localparam logic [7:0] CMD_CASET = 8'h2A;
  localparam logic [7:0] CMD_PASET = 8'h2B;
  localparam logic [7:0] CMD_RAMWR = 8'h2C;

  localparam int         NUM_EDGES = 15;
  localparam logic [3:0] LAST_EDGE = 4'(NUM_EDGES - 1);
  localparam logic [3:0] LAST_BYTE = 4'd12;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT,
    S_EDGE_SETUP,
    S_PIXEL,
    S_STEP,
    S_DONE
  } state_t;

  // Pentagon, spokes, pentagram; entry 15 pads the table to a power of two.
  localparam logic [3:0] EDGE_FROM [16] = '{
    4'd0, 4'd1, 4'd2, 4'd3, 4'd4,
    4'd0, 4'd1, 4'd2, 4'd3, 4'd4,
    4'd5, 4'd7, 4'd9, 4'd6, 4'd8,
    4'd0
  };
  localparam logic [3:0] EDGE_TO [16] = '{
    4'd1, 4'd2, 4'd3, 4'd4, 4'd0,
    4'd5, 4'd6, 4'd7, 4'd8, 4'd9,
    4'd7, 4'd9, 4'd6, 4'd8, 4'd5,
    4'd0
  };

endpackage

// File: rtl/spi_byte_tx.sv
// Byte serialiser: loads a byte plus its D/C flag and shifts it out MSB first, one bit
// per clock; o_done marks the final bit so the next byte can follow with no gap.
module spi_byte_tx (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_load,
  input  logic [7:0] i_byte,
  input  logic       i_dc,
  output logic       o_mosi,
  output logic       o_dc,
  output logic       o_busy,
  output logic       o_done
);

  logic [7:0] shreg;
  logic [2:0] bit_cnt;

  // NOTE: sequential state uses non-blocking assignments so every register samples
  // pre-edge values, independent of statement order.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      shreg   <= '0;
      bit_cnt <= '0;
      o_busy  <= 1'b0;
      o_dc    <= 1'b0;
    end else if (i_load) begin
      shreg   <= i_byte;
      bit_cnt <= '0;
      o_busy  <= 1'b1;
      o_dc    <= i_dc;
    end else if (o_busy) begin
      if (bit_cnt == 3'd7) begin
        o_busy <= 1'b0;          // last bit stays on the line while idle
      end else begin
        shreg   <= {shreg[6:0], 1'b0};
        bit_cnt <= bit_cnt + 3'd1;
      end
    end
  end

  assign o_mosi = shreg[7];
  assign o_done = o_busy && (bit_cnt == 3'd7);

endmodule

// File: rtl/spi_connect.sv
// Petersen-graph drawer: walks 15 edges with Bresenham and streams every pixel as a
// CASET/PASET/RAMWR transaction through spi_byte_tx, with no gaps between bytes.
module spi_connect
  import spi_connect_pkg::*;
#(
  parameter int unsigned DELAY = 20,
  parameter logic [15:0] X1 = 16'd12, parameter logic [15:0] Y1 = 16'd5,
  parameter logic [15:0] X2 = 16'd23, parameter logic [15:0] Y2 = 16'd12,
  parameter logic [15:0] X3 = 16'd19, parameter logic [15:0] Y3 = 16'd25,
  parameter logic [15:0] X4 = 16'd6,  parameter logic [15:0] Y4 = 16'd25,
  parameter logic [15:0] X5 = 16'd2,  parameter logic [15:0] Y5 = 16'd12,
  parameter logic [15:0] X1_2 = 16'd12, parameter logic [15:0] Y1_2 = 16'd9,
  parameter logic [15:0] X2_2 = 16'd18, parameter logic [15:0] Y2_2 = 16'd13,
  parameter logic [15:0] X3_2 = 16'd16, parameter logic [15:0] Y3_2 = 16'd20,
  parameter logic [15:0] X4_2 = 16'd8,  parameter logic [15:0] Y4_2 = 16'd20,
  parameter logic [15:0] X5_2 = 16'd6,  parameter logic [15:0] Y5_2 = 16'd13,
  parameter logic [15:0] COLOR = 16'hFFFF
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_start,
  output logic o_mosi,
  output logic o_dc,
  output logic o_cs,
  output logic o_done
);

  localparam logic [15:0] VX [16] = '{X1, X2, X3, X4, X5, X1_2, X2_2, X3_2, X4_2, X5_2,
                                      16'd0, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0};
  localparam logic [15:0] VY [16] = '{Y1, Y2, Y3, Y4, Y5, Y1_2, Y2_2, Y3_2, Y4_2, Y5_2,
                                      16'd0, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0};

  state_t             state, state_nxt;
  logic [15:0]        wait_cnt;
  logic [3:0]         edge_idx, byte_idx;
  logic [15:0]        cur_x, cur_y, end_x, end_y;
  logic signed [16:0] dx, dy, err;          // dx = |dx|, dy = -|dy|
  logic               x_neg, y_neg;

  logic               tx_load, tx_busy, tx_done, tx_dc;
  logic [7:0]         tx_byte;

  logic [15:0]        from_x, from_y, to_x, to_y;
  logic signed [16:0] diff_x, diff_y, abs_x, abs_y;
  logic signed [17:0] e2, dx_ext, dy_ext;
  logic               move_x, move_y, edge_end, last_edge, start_ok;

  always_comb begin
    from_x   = VX[EDGE_FROM[edge_idx]];
    from_y   = VY[EDGE_FROM[edge_idx]];
    to_x     = VX[EDGE_TO[edge_idx]];
    to_y     = VY[EDGE_TO[edge_idx]];
    diff_x   = $signed({1'b0, to_x}) - $signed({1'b0, from_x});
    diff_y   = $signed({1'b0, to_y}) - $signed({1'b0, from_y});
    abs_x    = diff_x[16] ? -diff_x : diff_x;
    abs_y    = diff_y[16] ? -diff_y : diff_y;
    e2       = {err, 1'b0};
    dx_ext   = {dx[16], dx};
    dy_ext   = {dy[16], dy};
    move_x   = (e2 >= dy_ext);
    move_y   = (e2 <= dx_ext);
    edge_end = (cur_x == end_x) && (cur_y == end_y);
    last_edge = (edge_idx == LAST_EDGE);
    start_ok = i_start && ((state == S_IDLE) || (state == S_DONE));
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) state <= S_IDLE;
    else       state <= state_nxt;
  end

  // NOTE: the default assignment first keeps this block purely combinational; a path
  // that leaves state_nxt unassigned would infer a latch.
  always_comb begin
    state_nxt = state;
    unique case (state)
      S_IDLE:       if (start_ok) state_nxt = S_WAIT;
      S_WAIT:       if (wait_cnt == 16'(DELAY - 1)) state_nxt = S_EDGE_SETUP;
      S_EDGE_SETUP: state_nxt = S_PIXEL;
      S_PIXEL:      if (tx_load && byte_idx == LAST_BYTE) state_nxt = S_STEP;
      S_STEP: begin
        if (!edge_end)      state_nxt = S_PIXEL;
        else if (!last_edge) state_nxt = S_EDGE_SETUP;
        else if (!tx_busy)  state_nxt = S_DONE;
      end
      S_DONE:       if (start_ok) state_nxt = S_WAIT;
      default:      state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    tx_load = (state == S_PIXEL) && (!tx_busy || tx_done);
    tx_dc   = 1'b1;
    unique case (byte_idx)
      4'd0:       begin tx_byte = CMD_CASET; tx_dc = 1'b0; end
      4'd1, 4'd3: tx_byte = cur_x[15:8];
      4'd2, 4'd4: tx_byte = cur_x[7:0];
      4'd5:       begin tx_byte = CMD_PASET; tx_dc = 1'b0; end
      4'd6, 4'd8: tx_byte = cur_y[15:8];
      4'd7, 4'd9: tx_byte = cur_y[7:0];
      4'd10:      begin tx_byte = CMD_RAMWR; tx_dc = 1'b0; end
      4'd11:      tx_byte = COLOR[15:8];
      default:    tx_byte = COLOR[7:0];
    endcase
    o_done = (state == S_DONE);
    o_cs   = ~tx_busy;
  end

  // Coordinates step while the final colour byte is still shifting out.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      wait_cnt <= '0;
      edge_idx <= '0;
      byte_idx <= '0;
      cur_x    <= '0;
      cur_y    <= '0;
      end_x    <= '0;
      end_y    <= '0;
      dx       <= '0;
      dy       <= '0;
      err      <= '0;
      x_neg    <= 1'b0;
      y_neg    <= 1'b0;
    end else begin
      unique case (state)
        S_IDLE, S_DONE: if (start_ok) begin
          wait_cnt <= '0;
          edge_idx <= '0;
          byte_idx <= '0;
        end
        S_WAIT: wait_cnt <= wait_cnt + 16'd1;
        S_EDGE_SETUP: begin
          cur_x <= from_x;
          cur_y <= from_y;
          end_x <= to_x;
          end_y <= to_y;
          dx    <= abs_x;
          dy    <= -abs_y;
          err   <= abs_x - abs_y;
          x_neg <= diff_x[16];
          y_neg <= diff_y[16];
        end
        S_PIXEL: if (tx_load) byte_idx <= (byte_idx == LAST_BYTE) ? 4'd0 : byte_idx + 4'd1;
        S_STEP: begin
          if (!edge_end) begin
            if (move_x) cur_x <= x_neg ? cur_x - 16'd1 : cur_x + 16'd1;
            if (move_y) cur_y <= y_neg ? cur_y - 16'd1 : cur_y + 16'd1;
            err <= err + (move_x ? dy : 17'sd0) + (move_y ? dx : 17'sd0);
          end else if (!last_edge) begin
            edge_idx <= edge_idx + 4'd1;
          end
        end
        default: ;
      endcase
    end
  end

  spi_byte_tx u_tx (
    .i_clk  (i_clk),
    .i_rst  (i_rst),
    .i_load (tx_load),
    .i_byte (tx_byte),
    .i_dc   (tx_dc),
    .o_mosi (o_mosi),
    .o_dc   (o_dc),
    .o_busy (tx_busy),
    .o_done (tx_done)
  );

endmodule

// File: tb/tb_spi_connect.sv
// Randomised-timing bench for spi_connect: decodes the serial stream from the pins and
// compares it with a pixel/byte list derived from the vertex table by plain Bresenham.
module tb_spi_connect;

  logic clk, rst, start;
  logic mosi, dc, cs, done;

  spi_connect dut (
    .i_clk   (clk),
    .i_rst   (rst),
    .i_start (start),
    .o_mosi  (mosi),
    .o_dc    (dc),
    .o_cs    (cs),
    .o_done  (done)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
  endtask

  // Reference: vertex coordinates and edge list straight from the drawing description.
  int vx [10] = '{12, 23, 19, 6, 2, 12, 18, 16, 8, 6};
  int vy [10] = '{5, 12, 25, 25, 12, 9, 13, 20, 20, 13};
  int ef [15] = '{0, 1, 2, 3, 4, 0, 1, 2, 3, 4, 5, 7, 9, 6, 8};
  int et [15] = '{1, 2, 3, 4, 0, 5, 6, 7, 8, 9, 7, 9, 6, 8, 5};

  logic [7:0] exp_b [$];
  logic       exp_dc [$];

  task automatic push_byte(input logic [7:0] b, input logic d);
    exp_b.push_back(b);
    exp_dc.push_back(d);
  endtask

  task automatic build_model();
    for (int e = 0; e < 15; e++) begin
      int x, y, x1, y1, ddx, ddy, sx, sy, err, e2;
      x = vx[ef[e]]; y = vy[ef[e]]; x1 = vx[et[e]]; y1 = vy[et[e]];
      ddx = (x1 > x) ? x1 - x : x - x1;
      ddy = -((y1 > y) ? y1 - y : y - y1);
      sx = (x < x1) ? 1 : -1;
      sy = (y < y1) ? 1 : -1;
      err = ddx + ddy;
      while (1) begin
        push_byte(8'h2A, 0);
        repeat (2) begin push_byte(8'(x >> 8), 1); push_byte(8'(x), 1); end
        push_byte(8'h2B, 0);
        repeat (2) begin push_byte(8'(y >> 8), 1); push_byte(8'(y), 1); end
        push_byte(8'h2C, 0);
        push_byte(8'hFF, 1);
        push_byte(8'hFF, 1);
        if (x == x1 && y == y1) break;
        e2 = 2 * err;
        if (e2 >= ddy) begin err += ddy; x += sx; end
        if (e2 <= ddx) begin err += ddx; y += sy; end
      end
    end
  endtask

  // Pin monitor: every cycle with cs low carries one bit.
  logic [7:0] obs_b [$];
  logic       obs_dc [$];
  logic [7:0] sh;
  logic       byte_dc;
  int         bit_n = 0;
  int         dc_glitch = 0;

  always @(negedge clk) begin
    if (cs === 1'b0) begin
      if (bit_n == 0) byte_dc = dc;
      else if (dc !== byte_dc) dc_glitch++;
      sh = {sh[6:0], mosi};
      bit_n++;
      if (bit_n == 8) begin
        obs_b.push_back(sh);
        obs_dc.push_back(byte_dc);
        bit_n = 0;
      end
    end else begin
      bit_n = 0;
    end
  end

  function automatic logic [31:0] px(input int p);
    if (13 * p + 12 >= obs_b.size()) return 32'hFFFF_FFFF;
    return {obs_b[13*p+1], obs_b[13*p+2], obs_b[13*p+6], obs_b[13*p+7]};
  endfunction

  task automatic check_reset_pins(input string tag);
    check({tag, "_mosi"}, 32'(mosi), 0);
    check({tag, "_dc"},   32'(dc),   0);
    check({tag, "_cs"},   32'(cs),   1);
    check({tag, "_done"}, 32'(done), 0);
  endtask

  // Pulse start, confirm cs-low latency and optional o_done clear.
  task automatic kick(input string tag);
    int lat;
    obs_b.delete();
    obs_dc.delete();
    dc_glitch = 0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check({tag, "_done_clear"}, 32'(done), 0);
    lat = 1;
    while (cs !== 1'b0 && lat < 100) begin
      @(negedge clk);
      lat++;
    end
    check({tag, "_cs_latency_ok"}, 32'(lat - 1 >= 20 && lat - 1 <= 22), 1);
  endtask

  task automatic run_draw(input string tag, input bit inject);
    int cyc, k1, k2, mism, dmism;
    kick(tag);
    k1 = $urandom_range(5, 15000);
    k2 = $urandom_range(5, 15000);
    cyc = 0;
    while (done !== 1'b1 && cyc < 50000) begin
      start = inject && (cyc == k1 || cyc == k2);
      @(negedge clk);
      cyc++;
    end
    start = 1'b0;
    check({tag, "_done"}, 32'(done), 1);
    check({tag, "_cs_high"}, 32'(cs), 1);
    check({tag, "_byte_count"}, obs_b.size(), 1976);
    mism = 0;
    dmism = 0;
    for (int i = 0; i < exp_b.size(); i++) begin
      if (i >= obs_b.size()) begin mism++; dmism++; end
      else begin
        if (obs_b[i] !== exp_b[i]) mism++;
        if (obs_dc[i] !== exp_dc[i]) dmism++;
      end
    end
    check({tag, "_byte_mismatches"}, mism, 0);
    check({tag, "_dc_mismatches"}, dmism, 0);
    check({tag, "_dc_stable"}, dc_glitch, 0);
  endtask

  logic [7:0] spec_b [13] = '{8'h2A, 8'h00, 8'h0C, 8'h00, 8'h0C, 8'h2B, 8'h00, 8'h05,
                              8'h00, 8'h05, 8'h2C, 8'hFF, 8'hFF};
  logic       spec_dc [13] = '{0, 1, 1, 1, 1, 0, 1, 1, 1, 1, 0, 1, 1};

  initial begin
    int bad, saved;
    clk = 0;
    rst = 1;
    start = 0;
    build_model();
    #3;
    check_reset_pins("por");
    repeat (2) @(negedge clk);
    rst = 0;
    repeat ($urandom_range(1, 8)) @(negedge clk);

    run_draw("run1", 1'b1);
    for (int i = 0; i < 13; i++) begin
      check($sformatf("first_byte%0d", i), (i < obs_b.size()) ? 32'(obs_b[i]) : 32'hX, 32'(spec_b[i]));
      check($sformatf("first_dc%0d", i), (i < obs_dc.size()) ? 32'(obs_dc[i]) : 32'hX, 32'(spec_dc[i]));
    end
    check("edge1_last_px", px(11), {16'd23, 16'd12});
    check("edge2_first_px", px(12), {16'd23, 16'd12});
    bad = 0;
    for (int i = 0; i < 14; i++) if (px(26 + i) !== {16'(19 - i), 16'd25}) bad++;
    check("edge3_px_errors", bad, 0);
    bad = 0;
    for (int i = 0; i < 5; i++) if (px(65 + i) !== {16'd12, 16'(5 + i)}) bad++;
    check("edge6_px_errors", bad, 0);
    check("edge7_first_px", px(70), {16'd23, 16'd12});
    check("last_px", px(151), {16'd12, 16'd9});

    repeat ($urandom_range(5, 50)) @(negedge clk);
    check("done_level", 32'(done), 1);
    check("cs_idle", 32'(cs), 1);

    run_draw("run2", 1'b0);

    kick("run3");
    repeat ($urandom_range(100, 8000)) @(negedge clk);
    @(posedge clk);
    #2 rst = 1;
    #1 check_reset_pins("mid_rst");
    saved = obs_b.size();
    @(negedge clk);
    rst = 0;
    bad = 0;
    repeat (300) begin
      @(negedge clk);
      if (cs !== 1'b1) bad++;
    end
    check("post_rst_cs_low_cycles", bad, 0);
    check("post_rst_new_bytes", obs_b.size() - saved, 0);
    check("post_rst_done", 32'(done), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
